// File: rtl/fetch_unit.sv
// fetch_unit: byte-serial instruction fetch stage.
//
// Each 32-bit instruction is built from four single-byte memory reads at
// pc+0..pc+3 (little-endian). The word is tagged with the branch predictor's
// next-PC / taken bit, which are sampled in the cycle the last byte returns.
// A one-entry skid buffer holds a finished word while the IF/ID slot is
// stalled. A redirect discards everything in flight. A byte that is still
// outstanding at that point is drained before fetching resumes.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   pc_out            current fetch PC (to predictor lookup)
//   pred_pc/pred_taken predictor result for pc_out (combinational)
//   mem_req/mem_addr  byte read request / byte address
//   mem_valid/mem_rdata one-cycle return pulse and data byte
//   stall             IF/ID cannot accept this cycle
//   redirect/redirect_pc  flush and restart at corrected PC
//   if_valid/if_inst/if_pc/if_pred  instruction slot towards IF/ID
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    input  logic [31:0] pred_pc,
    input  logic        pred_taken,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [7:0]  mem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_pred
);

    typedef enum logic [1:0] {FETCH, WAIT_OUT, DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [1:0]  byte_cnt, cnt_nx;
    logic        pending, pend_nx;     // a byte request has been accepted
    logic [23:0] asm_q, asm_nx;        // bytes 0..2 of the word in progress
    logic [31:0] buf_inst, buf_inst_nx;
    logic [31:0] buf_pc, buf_pc_nx;
    logic [31:0] buf_npc, buf_npc_nx;
    logic        buf_pred, buf_pred_nx;
    logic        ifv_nx;
    logic [31:0] ifi_nx, ifp_nx;
    logic        ifr_nx;
    logic [31:0] word;
    logic        slot_free;

    assign pc_out    = pc;
    assign mem_addr  = pc + {30'b0, byte_cnt};
    // Gated by rst so no request is shown while reset is held.
    assign mem_req   = rst && (state == FETCH) && !pending;
    assign word      = {mem_rdata, asm_q};
    assign slot_free = !if_valid || !stall;

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        cnt_nx      = byte_cnt;
        pend_nx     = pending;
        asm_nx      = asm_q;
        buf_inst_nx = buf_inst;
        buf_pc_nx   = buf_pc;
        buf_npc_nx  = buf_npc;
        buf_pred_nx = buf_pred;
        // slot empties when consumed; a load below overrides this
        ifv_nx      = if_valid && stall;
        ifi_nx      = if_inst;
        ifp_nx      = if_pc;
        ifr_nx      = if_pred;

        if (redirect) begin
            ifv_nx = 1'b0;
            pc_nx  = redirect_pc & ~32'h3;
            cnt_nx = 2'd0;
            // A request accepted this cycle (mem_req) or an earlier one
            // whose byte has not come back must be drained.
            if ((pending && !mem_valid) || mem_req) begin
                state_nx = DRAIN;
                pend_nx  = 1'b1;
            end else begin
                state_nx = FETCH;
                pend_nx  = 1'b0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (mem_req) begin
                        pend_nx = 1'b1;
                    end else if (pending && mem_valid) begin
                        pend_nx = 1'b0;
                        if (byte_cnt == 2'd3) begin
                            cnt_nx = 2'd0;
                            if (slot_free) begin
                                ifv_nx = 1'b1;
                                ifi_nx = word;
                                ifp_nx = pc;
                                ifr_nx = pred_taken;
                                pc_nx  = pred_pc;
                            end else begin
                                buf_inst_nx = word;
                                buf_pc_nx   = pc;
                                buf_npc_nx  = pred_pc;
                                buf_pred_nx = pred_taken;
                                state_nx    = WAIT_OUT;
                            end
                        end else begin
                            asm_nx[{byte_cnt, 3'b000} +: 8] = mem_rdata;
                            cnt_nx = byte_cnt + 2'd1;
                        end
                    end
                end
                WAIT_OUT: begin
                    // slot is always occupied here; it frees when stall drops
                    if (!stall) begin
                        ifv_nx   = 1'b1;
                        ifi_nx   = buf_inst;
                        ifp_nx   = buf_pc;
                        ifr_nx   = buf_pred;
                        pc_nx    = buf_npc;
                        cnt_nx   = 2'd0;
                        state_nx = FETCH;
                    end
                end
                DRAIN: begin
                    if (mem_valid) begin
                        pend_nx  = 1'b0;
                        state_nx = FETCH;
                    end
                end
                default: state_nx = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            byte_cnt <= 2'd0;
            pending  <= 1'b0;
            asm_q    <= 24'd0;
            buf_inst <= 32'd0;
            buf_pc   <= 32'd0;
            buf_npc  <= 32'd0;
            buf_pred <= 1'b0;
            if_valid <= 1'b0;
            if_inst  <= 32'd0;
            if_pc    <= 32'd0;
            if_pred  <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            byte_cnt <= cnt_nx;
            pending  <= pend_nx;
            asm_q    <= asm_nx;
            buf_inst <= buf_inst_nx;
            buf_pc   <= buf_pc_nx;
            buf_npc  <= buf_npc_nx;
            buf_pred <= buf_pred_nx;
            if_valid <= ifv_nx;
            if_inst  <= ifi_nx;
            if_pc    <= ifp_nx;
            if_pred  <= ifr_nx;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory responder with random latency,
// deterministic predictor, random stall/redirect, mid-run reset.
// Expected instruction stream and byte-address stream are derived from the
// program-flow rules (word = 4 memory bytes, next pc = predicted pc).
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_out, pred_pc, mem_addr, redirect_pc, if_inst, if_pc;
    logic        pred_taken, mem_req, mem_valid, stall, redirect, if_valid, if_pred;
    logic [7:0]  mem_rdata;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
        .if_inst(if_inst), .if_pc(if_pc), .if_pred(if_pred)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int consumed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // program image
    function automatic logic [7:0] mbyte(input logic [31:0] a);
        logic [31:0] t;
        if (a == 32'd0) return 8'h13;
        if (a == 32'd1) return 8'h05;
        if (a == 32'd2 || a == 32'd3) return 8'h00;
        t = (a * 32'd37) ^ (a >> 9) ^ 32'h5A;
        return t[7:0];
    endfunction

    // predictor: a taken branch in every word whose pc[5:2]==1
    function automatic logic ptaken(input logic [31:0] p);
        return p[5:2] == 4'd1;
    endfunction
    function automatic logic [31:0] pnext(input logic [31:0] p);
        return ptaken(p) ? p + 32'h3C : p + 32'h4;
    endfunction

    assign pred_taken = ptaken(pc_out);
    assign pred_pc    = pnext(pc_out);

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } exp_t;
    exp_t sb[$];

    logic [31:0] am_pc;   // expected address stream: word pc and byte index
    int          am_k;

    task automatic restart(input logic [31:0] p);
        logic [31:0] a;
        exp_t e;
        sb.delete();
        a = p & ~32'h3;
        am_pc = a;
        am_k = 0;
        for (int i = 0; i < 64; i++) begin
            e.inst = {mbyte(a + 32'd3), mbyte(a + 32'd2), mbyte(a + 32'd1), mbyte(a)};
            e.pc   = a;
            e.pred = ptaken(a);
            sb.push_back(e);
            a = pnext(a);
        end
    endtask

    // memory responder: deliver at +1, accept at +3
    logic        busy;
    int          cnt;
    logic [31:0] cur_addr, ret_addr;

    initial begin
        mem_valid = 1'b0;
        mem_rdata = 8'h00;
        busy = 1'b0;
        cnt = 0;
        cur_addr = 32'd0;
        ret_addr = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            mem_valid = 1'b0;
            if (!rst) begin
                busy = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = mbyte(cur_addr);
                    ret_addr  = cur_addr;
                    busy      = 1'b0;
                end
            end
            #2;
            if (rst && (busy || mem_valid)) begin
                chk("one_outstanding", {31'd0, mem_req}, 32'd0);
            end else if (rst && mem_req) begin
                cur_addr = mem_addr;
                busy = 1'b1;
                cnt = $urandom_range(1, 3);
                // a request issued alongside a redirect is drained, not checked
                if (!redirect) begin
                    chk("req_addr", mem_addr, am_pc + am_k);
                    am_k++;
                    if (am_k == 4) begin
                        am_k = 0;
                        am_pc = pnext(am_pc);
                    end
                end
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_pred", {31'd0, if_pred}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_pc_out", pc_out, RST_PC);
    endtask

    // driver at +2
    initial begin
        int since;
        logic r;
        logic [31:0] tgt;
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        since = 0;
        restart(RST_PC);
        @(negedge clk);
        #2;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("first_mem_req", {31'd0, mem_req}, 32'd1);
        chk("first_mem_addr", mem_addr, RST_PC);
        for (int cyc = 1; cyc <= 6000; cyc++) begin
            @(negedge clk);
            #2;
            redirect = 1'b0;
            if (cyc == 3000) begin
                rst = 1'b0;
                #1;
                chk_reset_outputs();
                restart(RST_PC);
                stall = 1'b0;
                repeat (2) @(negedge clk);
                #2;
                rst = 1'b1;
                #1;
                chk("rel_mem_req", {31'd0, mem_req}, 32'd1);
                chk("rel_mem_addr", mem_addr, RST_PC);
                since = 0;
                continue;
            end
            stall = ((cyc % 200) < 40) ? 1'b1 : ($urandom_range(0, 3) == 0);
            since++;
            r = 1'b0;
            tgt = 32'd0;
            case ($urandom_range(0, 3))
                0: tgt = {20'd0, 12'($urandom)};
                1: tgt = 32'hFFFF_FFFD;
                2: tgt = 32'h0000_0103;
                default: tgt = $urandom;
            endcase
            if (mem_valid && ret_addr[1:0] == 2'd3 && $urandom_range(0, 7) == 0) begin
                r = 1'b1;
                stall = 1'b1;
            end else if (busy && cur_addr[1:0] == 2'd2 && $urandom_range(0, 15) == 0) begin
                r = 1'b1;
                tgt = 32'h0000_0103;
            end else if ($urandom_range(0, 59) == 0 || since > 300) begin
                r = 1'b1;
            end
            if (r) begin
                redirect = 1'b1;
                redirect_pc = tgt;
                restart(tgt);
                since = 0;
            end
        end
        @(negedge clk);
        #2;
        redirect = 1'b0;
        stall = 1'b0;
        repeat (50) @(negedge clk);
        #2;
        total++;
        if (consumed < 50) begin
            bad++;
            $display("FAIL liveness consumed=%0d required>=50", consumed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // monitor at +4: pops the scoreboard on each consumed slot
    initial begin
        logic        prev_redir, prev_hold;
        logic [31:0] h_inst, h_pc;
        logic        h_pred;
        exp_t        e;
        prev_redir = 1'b0;
        prev_hold = 1'b0;
        h_inst = 32'd0;
        h_pc = 32'd0;
        h_pred = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                prev_redir = 1'b0;
                prev_hold = 1'b0;
                continue;
            end
            if (prev_redir) chk("valid_after_redirect", {31'd0, if_valid}, 32'd0);
            if (prev_hold) begin
                chk("hold_inst", if_inst, h_inst);
                chk("hold_pc", if_pc, h_pc);
                chk("hold_pred", {31'd0, if_pred}, {31'd0, h_pred});
            end
            if (if_valid && !stall && !redirect) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty if_pc=%h required=none", if_pc);
                end else begin
                    e = sb.pop_front();
                    chk("if_inst", if_inst, e.inst);
                    chk("if_pc", if_pc, e.pc);
                    chk("if_pred", {31'd0, if_pred}, {31'd0, e.pred});
                    consumed++;
                end
            end
            prev_redir = redirect;
            prev_hold  = if_valid && stall && !redirect;
            h_inst = if_inst;
            h_pc   = if_pc;
            h_pred = if_pred;
        end
    end

endmodule
